// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned INSTR_WORDS    = 128;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Little-endian byte-to-word assembler: each loaded byte lands in the lane
// selected by a wrapping index; word_full flags the byte that completes a word.
module word_assembler
  import loader_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             load,
  input  logic [BYTE_W-1:0]                byte_in,
  output logic [BYTES_PER_WORD*BYTE_W-1:0] word,
  output logic                             word_full
);

  localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] idx;

  assign word_full = load && (idx == IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      word <= '0;
    end else if (clr) begin
      idx  <= '0;
      word <= '0;
    end else if (load) begin
      word[{idx, 3'b000} +: BYTE_W] <= byte_in;
      idx                           <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Streams a length-prefixed byte image into instruction memory and holds the CPU
// in reset while loading. Optional checksum byte: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state_q, state_d;
  logic              accept;
  logic              len_accept;
  logic              data_load;
  logic              word_full;
  logic              last_word;
  logic [7:0]        len_m1;
  logic [ADDR_W-1:0] last_addr_q;

  assign accept     = byte_valid && byte_ready;
  assign len_accept = accept && (state_q == LEN);
  assign data_load  = accept && (state_q == DATA);
  assign last_word  = (mem_addr == last_addr_q);
  // N=0 wraps to all-ones, i.e. a full 2^ADDR_W-word image
  assign len_m1     = byte_in - 8'd1;

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
      error  <= 1'b0;
    end else begin
      error <= (state_d == ERR);
      if (len_accept)     csum_q <= '0;
      else if (data_load) csum_q <= csum_q ^ byte_in;
    end
  end
`else
  assign error = 1'b0;
`endif

  word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (len_accept),
    .load      (data_load),
    .byte_in   (byte_in),
    .word      (mem_data),
    .word_full (word_full)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = LEN;
      LEN:   if (accept) state_d = DATA;
      DATA:  if (word_full) state_d = WRITE;
      WRITE: begin
        if (!last_word) begin
          state_d = DATA;
        end else begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      CHK:   if (accept) state_d = (byte_in == csum_q) ? DONE : ERR;
`endif
      DONE:  if (start) state_d = LEN;
      ERR:   if (start) state_d = LEN;
      default: state_d = IDLE;
    endcase
  end

  // State register; outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_ready  <= 1'b0;
      mem_w_en    <= 1'b0;
      mem_addr    <= '0;
      last_addr_q <= '0;
      cpu_rst_n   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_ready <= (state_d == LEN) || (state_d == DATA) || (state_d == CHK);
      mem_w_en   <= (state_d == WRITE);
      busy       <= (state_d == LEN) || (state_d == DATA) ||
                    (state_d == WRITE) || (state_d == CHK);
      cpu_rst_n  <= (state_d == IDLE) || (state_d == DONE);
      done       <= (state_d == DONE);
      if (len_accept) begin
        mem_addr    <= '0;
        last_addr_q <= ADDR_W'(len_m1);
      end else if ((state_q == WRITE) && !last_word) begin
        mem_addr <= mem_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader; checksum steps follow
// INSTR_LOADER_CHECKSUM_EN.
module tb_instr_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_w_en;
  logic [6:0]  mem_addr;
  logic [31:0] mem_data;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [6:0]  wr_addr [256];
  logic [31:0] wr_data [256];
  int          wr_n = 0;

  instr_loader #(.ADDR_W(7), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_w_en   (mem_w_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Record every memory write; the loader must not offer ready while writing
  always @(negedge clk) begin
    if (mem_w_en === 1'b1) begin
      if (wr_n < 256) begin
        wr_addr[wr_n] = mem_addr;
        wr_data[wr_n] = mem_data;
      end
      wr_n++;
      check("ready_in_write", byte_ready, 0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("ready_timeout", 0, 1);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int t = 0;
    while (done !== 1'b1 && error !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("end_timeout", (t < 50), 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_byte_ready", byte_ready, 0);
    check("rst_mem_w_en",   mem_w_en,   0);
    check("rst_mem_addr",   mem_addr,   0);
    check("rst_mem_data",   mem_data,   0);
    check("rst_cpu_rst_n",  cpu_rst_n,  1);
    check("rst_busy",       busy,       0);
    check("rst_done",       done,       0);
    check("rst_error",      error,      0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", byte_ready, 0);

    // Single-word load
    wr_n = 0;
    pulse_start();
    check("len_ready",     byte_ready, 1);
    check("len_cpu_rst_n", cpu_rst_n,  0);
    check("len_busy",      busy,       1);
    send_byte(8'h01);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(8'h08);
`endif
    wait_end();
    check("t1_writes",    wr_n,       1);
    check("t1_addr",      wr_addr[0], 0);
    check("t1_data",      wr_data[0], 32'h12345678);
    check("t1_done",      done,       1);
    check("t1_error",     error,      0);
    check("t1_cpu_rst_n", cpu_rst_n,  1);
    check("t1_busy",      busy,       0);

    // Two words, valid dropped between bytes and held during WRITE
    wr_n = 0;
    pulse_start();
    check("t2_done_cleared", done, 0);
    send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(8'h44);
`endif
    wait_end();
    check("t2_writes", wr_n,       2);
    check("t2_addr0",  wr_addr[0], 0);
    check("t2_data0",  wr_data[0], 32'hDDCCBBAA);
    check("t2_addr1",  wr_addr[1], 1);
    check("t2_data1",  wr_data[1], 32'h44332211);
    check("t2_done",   done,       1);

    // start mid-load is ignored
    wr_n = 0;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    pulse_start();
    check("t3_busy_after_start", busy, 1);
    send_byte(8'h05); send_byte(8'h06);
    pulse_start();
    send_byte(8'h07); send_byte(8'h08);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(8'h08);
`endif
    wait_end();
    check("t3_writes", wr_n,       2);
    check("t3_data0",  wr_data[0], 32'h04030201);
    check("t3_addr1",  wr_addr[1], 1);
    check("t3_data1",  wr_data[1], 32'h08070605);
    check("t3_done",   done,       1);

    // Asynchronous reset after the 2nd data byte
    wr_n = 0;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'hEF);
    send_byte(8'hBE);
    #2 rst_n = 1'b0;
    #1;
    check("ar_mem_w_en",   mem_w_en,   0);
    check("ar_cpu_rst_n",  cpu_rst_n,  1);
    check("ar_busy",       busy,       0);
    check("ar_byte_ready", byte_ready, 0);
    check("ar_done",       done,       0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ar_no_write", wr_n, 0);
    check("ar_idle",     busy, 0);
    pulse_start();
    send_byte(8'h01);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(8'h22);
`endif
    wait_end();
    check("ar_writes", wr_n,       1);
    check("ar_addr",   wr_addr[0], 0);
    check("ar_data",   wr_data[0], 32'hDEADBEEF);
    check("ar_done",   done,       1);

    // N=0 loads the full 128-word image
    wr_n = 0;
    pulse_start();
    send_byte(8'h00);
    for (int i = 0; i < 512; i++) send_byte(8'(i));
`ifdef INSTR_LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    wait_end();
    check("full_writes", wr_n, 128);
    for (int k = 0; k < 128; k++) begin
      logic [31:0] exp_w;
      exp_w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      check($sformatf("full_addr%0d", k), wr_addr[k], 32'(k));
      check($sformatf("full_data%0d", k), wr_data[k], exp_w);
    end
    check("full_done",     done,      1);
    check("full_cpu_rst",  cpu_rst_n, 1);
    check("full_addr_end", mem_addr,  127);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Bad checksum holds the CPU; good checksum releases it
    wr_n = 0;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05);
    wait_end();
    check("cs_bad_error",   error,     1);
    check("cs_bad_done",    done,      0);
    check("cs_bad_cpu_rst", cpu_rst_n, 0);
    check("cs_bad_writes",  wr_n,      1);
    pulse_start();
    check("cs_err_cleared", error, 0);
    send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h04);
    wait_end();
    check("cs_good_done",    done,      1);
    check("cs_good_error",   error,     0);
    check("cs_good_cpu_rst", cpu_rst_n, 1);
`else
    check("nocs_error_low", error, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
